score_bin_to_bcd: RTL and testbench



---
 rtl/score_bin_to_bcd.sv | 109 ++++++++++
 tb/tb_score_bin_to_bcd.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble) producing three display digits.
// Operands above 999 saturate to 999 and set ovf.

module bcd_nib_adj (
  input  logic [3:0] nin,
  output logic [3:0] nout
);
  assign nout = (nin >= 4'd5) ? nin + 4'd3 : nin;
endmodule

module score_bin_to_bcd #(
  parameter int BIN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [3:0]           bcd0,
  output logic [3:0]           bcd1,
  output logic [3:0]           bcd2
);
  localparam int CW = $clog2(BIN_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;

  logic [BIN_WIDTH-1:0] op, op_in;
  logic [2:0][3:0]      acc, acc_adj;
  logic [11:0]          adj_flat, acc_sh;
  logic [CW-1:0]        cnt;
  logic                 ovf_next, over, last;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_nib
      bcd_nib_adj u_adj (.nin(acc[g]), .nout(acc_adj[g]));
    end
    // Narrow operands can never exceed 999, so saturation drops out entirely.
    if (BIN_WIDTH >= 10) begin : g_sat
      assign over  = bin > BIN_WIDTH'(999);
      assign op_in = over ? BIN_WIDTH'(999) : bin;
    end else begin : g_nosat
      assign over  = 1'b0;
      assign op_in = bin;
    end
  endgenerate

  assign adj_flat = acc_adj;
  assign acc_sh   = {adj_flat[10:0], op[BIN_WIDTH-1]};
  assign last     = (cnt == CW'(BIN_WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = SHIFT;
      SHIFT: if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd0     <= 4'd0;
      bcd1     <= 4'd0;
      bcd2     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op       <= op_in;
          ovf_next <= over;
          acc      <= '0;
          cnt      <= '0;
          busy     <= 1'b1;
        end
        SHIFT: begin
          acc <= acc_sh;
          op  <= op << 1;
          cnt <= cnt + CW'(1);
          // Final iteration publishes the shifted digits on the same edge.
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            ovf  <= ovf_next;
            bcd0 <= acc_sh[3:0];
            bcd1 <= acc_sh[7:4];
            bcd2 <= acc_sh[11:8];
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bin_to_bcd.sv
// Randomized and directed bench for score_bin_to_bcd against an arithmetic decimal model.

module tb_score_bin_to_bcd;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [9:0] bin = '0;
  logic busy, done, ovf;
  logic [3:0] bcd0, bcd1, bcd2;

  logic start4 = 1'b0;
  logic [3:0] bin4 = '0;
  logic busy4, done4, ovf4;
  logic [3:0] d40, d41, d42;

  logic start16 = 1'b0;
  logic [15:0] bin16 = '0;
  logic busy16, done16, ovf16;
  logic [3:0] d160, d161, d162;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  score_bin_to_bcd u_dut (.clk(clk), .reset(reset), .start(start), .bin(bin), .busy(busy),
    .done(done), .ovf(ovf), .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2));
  score_bin_to_bcd #(.BIN_WIDTH(4)) u_w4 (.clk(clk), .reset(reset), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .ovf(ovf4), .bcd0(d40), .bcd1(d41), .bcd2(d42));
  score_bin_to_bcd #(.BIN_WIDTH(16)) u_w16 (.clk(clk), .reset(reset), .start(start16), .bin(bin16),
    .busy(busy16), .done(done16), .ovf(ovf16), .bcd0(d160), .bcd1(d161), .bcd2(d162));

  function automatic logic [11:0] ref_bcd(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic start_main(input int v);
    @(negedge clk);
    bin = 10'(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      total++;
      if ({bcd2, bcd1, bcd0, busy, done, ovf} !== 15'd0)
        $display("FAIL reset_state got=%h/%b%b%b exp=000/000", {bcd2, bcd1, bcd0}, busy, done, ovf);
      else pass_cnt++;
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_basic();
    int vals[4] = '{0, 7, 123, 999};
    int lat;
    foreach (vals[i]) begin
      start_main(vals[i]);
      total++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL basic_busy v=%0d busy=%b done=%b exp busy=1 done=0", vals[i], busy, done);
      else pass_cnt++;
      wait_done(lat);
      total++;
      if (lat !== 10 || busy !== 1'b0) $display("FAIL basic_lat v=%0d got=%0d busy=%b exp=10 busy=0", vals[i], lat, busy);
      else pass_cnt++;
      total++;
      if ({bcd2, bcd1, bcd0} !== ref_bcd(vals[i]) || ovf !== 1'b0)
        $display("FAIL basic_digits v=%0d got=%h ovf=%b exp=%h ovf=0", vals[i], {bcd2, bcd1, bcd0}, ovf, ref_bcd(vals[i]));
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int vals[3] = '{1000, 1023, 42};
    int lat;
    foreach (vals[i]) begin
      start_main(vals[i]);
      wait_done(lat);
      total++;
      if (lat !== 10 || {bcd2, bcd1, bcd0} !== ref_bcd(vals[i]) || ovf !== (vals[i] > 999))
        $display("FAIL sat v=%0d lat=%0d got=%h ovf=%b exp lat=10 %h ovf=%b", vals[i], lat,
                 {bcd2, bcd1, bcd0}, ovf, ref_bcd(vals[i]), vals[i] > 999);
      else pass_cnt++;
    end
  endtask

  task automatic test_held();
    int lat, extra;
    start_main(500);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bin = 10'd11;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    total++;
    if (lat !== 7 || {bcd2, bcd1, bcd0} !== 12'h500)
      $display("FAIL held_first lat=%0d got=%h exp lat=7 500", lat, {bcd2, bcd1, bcd0});
    else pass_cnt++;
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    total++;
    if (extra !== 0 || {bcd2, bcd1, bcd0} !== 12'h500)
      $display("FAIL held_after activity=%0d got=%h exp activity=0 500", extra, {bcd2, bcd1, bcd0});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    start_main(250);
    wait_done(lat);
    total++;
    if (lat !== 10 || {bcd2, bcd1, bcd0} !== 12'h250)
      $display("FAIL b2b_first lat=%0d got=%h exp lat=10 250", lat, {bcd2, bcd1, bcd0});
    else pass_cnt++;
    bin = 10'd31;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept busy=%b done=%b exp busy=1 done=0", busy, done);
    else pass_cnt++;
    wait_done(lat);
    total++;
    if (lat !== 10 || {bcd2, bcd1, bcd0} !== 12'h031)
      $display("FAIL b2b_second lat=%0d got=%h exp lat=10 031", lat, {bcd2, bcd1, bcd0});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    start_main(876);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || {bcd2, bcd1, bcd0} !== 12'h000)
      $display("FAIL rstmid_state busy=%b done=%b got=%h exp busy=0 done=0 000", busy, done, {bcd2, bcd1, bcd0});
    else pass_cnt++;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL rstmid_nodone got=%0d exp=0", seen);
    else pass_cnt++;
    start_main(876);
    wait_done(lat);
    total++;
    if (lat !== 10 || {bcd2, bcd1, bcd0} !== 12'h876)
      $display("FAIL rstmid_retry lat=%0d got=%h exp lat=10 876", lat, {bcd2, bcd1, bcd0});
    else pass_cnt++;
  endtask

  task automatic run_w16(input int v, output int lat);
    @(negedge clk);
    bin16 = 16'(v);
    start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done16) begin lat = k; break; end
    end
  endtask

  task automatic test_param();
    int lat;
    @(negedge clk);
    bin4 = 4'd15;
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done4) begin lat = k; break; end
    end
    total++;
    if (lat !== 4 || {d42, d41, d40} !== 12'h015 || ovf4 !== 1'b0)
      $display("FAIL w4_15 lat=%0d got=%h ovf=%b exp lat=4 015 ovf=0", lat, {d42, d41, d40}, ovf4);
    else pass_cnt++;
    run_w16(65535, lat);
    total++;
    if (lat !== 16 || {d162, d161, d160} !== 12'h999 || ovf16 !== 1'b1)
      $display("FAIL w16_max lat=%0d got=%h ovf=%b exp lat=16 999 ovf=1", lat, {d162, d161, d160}, ovf16);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int v, lat;
    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 1023));
      start_main(v);
      wait_done(lat);
      total++;
      if (lat !== 10 || {bcd2, bcd1, bcd0} !== ref_bcd(v) || ovf !== (v > 999))
        $display("FAIL rand10 v=%0d lat=%0d got=%h ovf=%b exp lat=10 %h ovf=%b", v, lat,
                 {bcd2, bcd1, bcd0}, ovf, ref_bcd(v), v > 999);
      else pass_cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(0, 1200)) : int'($urandom_range(0, 65535));
      run_w16(v, lat);
      total++;
      if (lat !== 16 || {d162, d161, d160} !== ref_bcd(v) || ovf16 !== (v > 999))
        $display("FAIL rand16 v=%0d lat=%0d got=%h ovf=%b exp lat=16 %h ovf=%b", v, lat,
                 {d162, d161, d160}, ovf16, ref_bcd(v), v > 999);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_held();
    test_back_to_back();
    test_reset_mid();
    test_param();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
